// File: rtl/graphics_tile_map_pkg.sv
// Shared definitions for the tile-map renderer: tile codes, 24-bit RGB colours,
// pipeline latency, the map FSM state type and the tile colour lookup.
package graphics_tile_map_pkg;

  localparam int GFX_LAT = 3;

  localparam logic [7:0] TILE_EMPTY = 8'd0;
  localparam logic [7:0] TILE_WALL  = 8'd1;
  localparam logic [7:0] TILE_DIRT  = 8'd2;
  localparam logic [7:0] TILE_CLEAN = 8'd3;

  localparam logic [23:0] COL_BLACK   = 24'h000000;
  localparam logic [23:0] COL_OUTSIDE = 24'h202020;
  localparam logic [23:0] COL_GRID    = 24'h404040;
  localparam logic [23:0] COL_ROBOT   = 24'hFFFFFF;
  localparam logic [23:0] COL_EMPTY   = 24'h808000;
  localparam logic [23:0] COL_WALL    = 24'h000080;
  localparam logic [23:0] COL_DIRT    = 24'h603000;
  localparam logic [23:0] COL_CLEAN   = 24'h008080;
  localparam logic [23:0] COL_RSVD    = 24'h800080;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } map_state_e;

  function automatic logic [23:0] tile_colour(input logic [7:0] code);
    logic [23:0] c;
    case (code)
      TILE_EMPTY: c = COL_EMPTY;
      TILE_WALL:  c = COL_WALL;
      TILE_DIRT:  c = COL_DIRT;
      TILE_CLEAN: c = COL_CLEAN;
      default:    c = COL_RSVD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/graphics_tile_map_ram.sv
// Simple dual-port tile RAM: one write port, one synchronous read port.
// Read-first: a read and write to the same address in one cycle returns old data.
module tile_map_ram #(
  parameter int DEPTH = 300,
  parameter int WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/graphics_tile_map.sv
// Tile-map pixel generator: clears the map after reset, then renders the map,
// grid borders and a blinking robot cell through a fixed 3-stage pixel pipeline.
module graphics_tile_map
  import graphics_tile_map_pkg::*;
#(
  parameter int MAX_X        = 640,
  parameter int MAX_Y        = 480,
  parameter int TILE_LOG2    = 5,
  parameter int COLS         = 20,
  parameter int ROWS         = 15,
  parameter int CODE_W       = 3,
  parameter int BLINK_FRAMES = 30,
  parameter int GRID_EN      = 1
) (
  input  logic                     clock_50,
  input  logic                     reset,
  input  logic                     video_on,
  input  logic [9:0]               pix_x,
  input  logic [9:0]               pix_y,
  input  logic                     wr_en,
  input  logic [$clog2(COLS)-1:0]  wr_col,
  input  logic [$clog2(ROWS)-1:0]  wr_row,
  input  logic [CODE_W-1:0]        wr_code,
  output logic                     wr_ready,
  input  logic [$clog2(COLS)-1:0]  robot_col,
  input  logic [$clog2(ROWS)-1:0]  robot_row,
  output logic [7:0]               graph_r,
  output logic [7:0]               graph_g,
  output logic [7:0]               graph_b,
  output logic                     frame_tick,
  output map_state_e               dbg_state
);

  localparam int DEPTH  = COLS * ROWS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int TW     = 10 - TILE_LOG2;
  localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  map_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [CODE_W-1:0]   ram_wdata;
  logic [CODE_W-1:0]   ram_rdata;
  logic                wr_in_range;
  logic [ADDR_W-1:0]   wr_addr;

  assign dbg_state   = state_q;
  assign wr_in_range = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
  assign wr_addr     = ADDR_W'(ADDR_W'(wr_row) * ADDR_W'(COLS) + ADDR_W'(wr_col));

  // Write port: a write takes effect on any posedge where wr_en and wr_ready
  // are both high; wr_en while wr_ready is low is silently ignored, no stall.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ram_we     = 1'b0;
    ram_waddr  = '0;
    ram_wdata  = '0;
    wr_ready   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr_q;
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
        else clr_addr_d = clr_addr_q + 1'b1;
      end
      ST_RUN: begin
        wr_ready = ~reset;
        if (wr_en && wr_in_range) begin
          ram_we    = 1'b1;
          ram_waddr = wr_addr;
          ram_wdata = wr_code;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Stage 1 combinational decode of the incoming pixel
  logic [TW-1:0]     tile_col, tile_row;
  logic              in_grid, border, robot_hit;
  logic [ADDR_W-1:0] rd_addr;

  assign tile_col  = pix_x[9:TILE_LOG2];
  assign tile_row  = pix_y[9:TILE_LOG2];
  assign in_grid   = (32'(pix_x) < (COLS << TILE_LOG2)) && (32'(pix_y) < (ROWS << TILE_LOG2));
  assign border    = (pix_x[TILE_LOG2-1:0] == '0) || (pix_y[TILE_LOG2-1:0] == '0);
  assign robot_hit = (tile_col == TW'(robot_col)) && (tile_row == TW'(robot_row));
  // Out-of-grid pixels read address 0 so the RAM is never indexed past its end.
  assign rd_addr   = in_grid ? ADDR_W'(ADDR_W'(tile_row) * ADDR_W'(COLS) + ADDR_W'(tile_col)) : '0;

  logic              s1_video, s1_in_grid, s1_border, s1_robot;
  logic [ADDR_W-1:0] s1_addr;
  logic              s2_video, s2_in_grid, s2_border, s2_robot;
  logic              blink_phase;
  logic [BW-1:0]     blink_cnt;
  logic [23:0]       pix_rgb;

  tile_map_ram #(.DEPTH(DEPTH), .WIDTH(CODE_W)) u_ram (
    .clk   (clock_50),
    .we    (ram_we & ~reset),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (s1_addr),
    .rdata (ram_rdata)
  );

  always_comb begin
    pix_rgb = COL_BLACK;
    if (state_q != ST_RUN || !s2_video)    pix_rgb = COL_BLACK;
    else if (!s2_in_grid)                  pix_rgb = COL_OUTSIDE;
    else if (s2_robot && blink_phase)      pix_rgb = COL_ROBOT;
    else if ((GRID_EN != 0) && s2_border)  pix_rgb = COL_GRID;
    else                                   pix_rgb = tile_colour(8'(ram_rdata));
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      s1_video   <= 1'b0;
      s1_in_grid <= 1'b0;
      s1_border  <= 1'b0;
      s1_robot   <= 1'b0;
      s1_addr    <= '0;
      s2_video   <= 1'b0;
      s2_in_grid <= 1'b0;
      s2_border  <= 1'b0;
      s2_robot   <= 1'b0;
      graph_r    <= 8'd0;
      graph_g    <= 8'd0;
      graph_b    <= 8'd0;
    end else begin
      s1_video   <= video_on;
      s1_in_grid <= in_grid;
      s1_border  <= border;
      s1_robot   <= robot_hit;
      s1_addr    <= rd_addr;
      s2_video   <= s1_video;
      s2_in_grid <= s1_in_grid;
      s2_border  <= s1_border;
      s2_robot   <= s1_robot;
      {graph_r, graph_g, graph_b} <= pix_rgb;
    end
  end

  // Frame tick is not delayed with the pixel pipe; it marks the last active pixel.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      frame_tick  <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      frame_tick <= (pix_x == 10'(MAX_X - 1)) && (pix_y == 10'(MAX_Y - 1));
      if (frame_tick) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_graphics_tile_map.sv
// Directed bench for graphics_tile_map: clear sequence, tile writes, latency,
// colour priority, read-first collision, blink timing and mid-run reset.
module tb_graphics_tile_map;
  import graphics_tile_map_pkg::*;

  logic       clock_50 = 1'b0;
  logic       reset;
  logic       video_on;
  logic [9:0] pix_x, pix_y;
  logic       wr_en;
  logic [4:0] wr_col;
  logic [3:0] wr_row;
  logic [2:0] wr_code;
  logic       wr_ready;
  logic [4:0] robot_col;
  logic [3:0] robot_row;
  logic [7:0] graph_r, graph_g, graph_b;
  logic       frame_tick;
  map_state_e dbg_state;

  int checks = 0;
  int errors = 0;
  int ft_count = 0;

  // clock / reset block
  always #10 clock_50 = ~clock_50;

  always @(negedge clock_50) if (frame_tick) ft_count++;

  graphics_tile_map dut (
    .clock_50  (clock_50),
    .reset     (reset),
    .video_on  (video_on),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .wr_en     (wr_en),
    .wr_col    (wr_col),
    .wr_row    (wr_row),
    .wr_code   (wr_code),
    .wr_ready  (wr_ready),
    .robot_col (robot_col),
    .robot_row (robot_row),
    .graph_r   (graph_r),
    .graph_g   (graph_g),
    .graph_b   (graph_b),
    .frame_tick(frame_tick),
    .dbg_state (dbg_state)
  );

  task automatic tick();
    @(posedge clock_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, graph_r, graph_g, graph_b};
  endfunction

  // driver tasks
  task automatic set_pix(input int x, input int y, input logic v);
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    video_on = v;
  endtask

  task automatic write_tile(input int col, input int row, input int code);
    wr_en   = 1'b1;
    wr_col  = 5'(col);
    wr_row  = 4'(row);
    wr_code = 3'(code);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pix_check(input string tag, input int x, input int y, input logic v,
                           input logic [23:0] exp);
    set_pix(x, y, v);
    repeat (GFX_LAT) tick();
    chk(tag, rgb(), {8'h00, exp});
  endtask

  task automatic wait_ready(input string tag, output int low_cycles, output int rgb_nz);
    low_cycles = 1;
    rgb_nz     = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (wr_ready) break;
      low_cycles++;
      if (rgb() != 32'd0) rgb_nz++;
    end
    wr_en = 1'b0;
    chk({tag, "_ready"}, {31'd0, wr_ready}, 32'd1);
  endtask

  initial begin
    int lows, nz;
    reset = 1'b1; video_on = 1'b0; pix_x = '0; pix_y = '0;
    wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_code = '0;
    robot_col = 5'd19; robot_row = 4'd14;
    tick();
    chk("rst_rgb", rgb(), 32'd0);
    chk("rst_tick", {31'd0, frame_tick}, 32'd0);
    chk("rst_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_CLEAR));

    // Clear runs with a visible in-grid pixel and a write that must be ignored
    reset = 1'b0;
    set_pix(37, 40, 1'b1);
    wr_en = 1'b1; wr_col = 5'd1; wr_row = 4'd1; wr_code = 3'd3;
    wait_ready("clear", lows, nz);
    chk("clear_len", 32'(lows), 32'd300);
    chk("clear_rgb_zero", 32'(nz), 32'd0);
    chk("run_state", 32'(dbg_state), 32'(ST_RUN));
    pix_check("clear_ignored_wr", 37, 40, 1'b1, 24'h808000);

    // Wall tile and exact latency
    write_tile(3, 2, 1);
    set_pix(100, 70, 1'b1);
    tick(); tick();
    chk("lat_before", rgb(), 32'h808000);
    tick();
    chk("wall_lat3", rgb(), 32'h000080);
    pix_check("border", 96, 70, 1'b1, 24'h404040);

    // Out-of-range writes dropped
    write_tile(20, 2, 1);
    write_tile(3, 15, 2);
    pix_check("oor_col_tile03", 5, 101, 1'b1, 24'h808000);
    pix_check("oor_keep_wall", 100, 70, 1'b1, 24'h000080);
    pix_check("oor_tile190", 613, 5, 1'b1, 24'h808000);

    // Same-cycle write/read of tile (5,5): old colour then new
    set_pix(165, 165, 1'b1);
    tick();
    set_pix(166, 165, 1'b1);
    wr_en = 1'b1; wr_col = 5'd5; wr_row = 4'd5; wr_code = 3'd2;
    tick();
    wr_en = 1'b0;
    tick();
    chk("rfirst_old", rgb(), 32'h808000);
    tick();
    chk("rfirst_new", rgb(), 32'h603000);

    // Remaining codes and priority
    write_tile(7, 7, 3);
    pix_check("clean", 234, 234, 1'b1, 24'h008080);
    write_tile(8, 7, 5);
    pix_check("reserved", 266, 234, 1'b1, 24'h800080);
    pix_check("video_off", 100, 70, 1'b0, 24'h000000);
    pix_check("outside_x", 640, 100, 1'b1, 24'h202020);
    pix_check("outside_y", 100, 480, 1'b1, 24'h202020);
    pix_check("outside_vid_off", 700, 100, 1'b0, 24'h000000);

    // Blink: 60 abbreviated frames, robot on tile (0,0)
    robot_col = 5'd0; robot_row = 4'd0;
    ft_count = 0;
    for (int f = 0; f < 60; f++) begin
      pix_check($sformatf("blink_f%0d", f), 5, 5, 1'b1, (f < 30) ? 24'hFFFFFF : 24'h808000);
      set_pix(639, 479, 1'b1);
      tick();
    end
    pix_check("blink_restore", 5, 5, 1'b1, 24'hFFFFFF);
    chk("tick_count", 32'(ft_count), 32'd60);
    pix_check("robot_over_border", 0, 5, 1'b1, 24'hFFFFFF);

    // Reset in RUN restarts clear and wipes the map
    set_pix(100, 70, 1'b1);
    reset = 1'b1;
    tick();
    chk("rerst_rgb", rgb(), 32'd0);
    chk("rerst_ready", {31'd0, wr_ready}, 32'd0);
    chk("rerst_state", 32'(dbg_state), 32'(ST_CLEAR));
    reset = 1'b0;
    wait_ready("reclear", lows, nz);
    chk("reclear_len", 32'(lows), 32'd300);
    pix_check("reclear_wall_gone", 100, 70, 1'b1, 24'h808000);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
